svpwm_gate_driver: RTL and testbench



---
 rtl/svpwm_pkg.sv | 27 ++
 rtl/svpwm_deadtime_leg.sv | 72 +++++++
 rtl/svpwm_gate_driver.sv | 139 +++++++++++++
 tb/tb_svpwm_gate_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/svpwm_pkg.sv
// rtl/svpwm_pkg.sv - shared types, widths and helpers for the SVPWM gate driver
package svpwm_pkg;

    localparam int MOD_W = 16;

    typedef enum logic [1:0] {
        LEG_DEAD    = 2'b00,
        LEG_HIGH_ON = 2'b01,
        LEG_LOW_ON  = 2'b10
    } leg_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic signed [MOD_W-1:0] clamp_mod(
        input logic signed [MOD_W-1:0] value,
        input logic signed [MOD_W-1:0] peak
    );
        if (value > peak) begin
            return peak;
        end else if (value < -peak) begin
            return -peak;
        end
        return value;
    endfunction

endpackage

// File: rtl/svpwm_deadtime_leg.sv
// rtl/svpwm_deadtime_leg.sv - one inverter leg: complementary gates with dead-time insertion
module svpwm_deadtime_leg
    import svpwm_pkg::*;
#(
    parameter int DEAD_CYCLES = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic cmd,
    input  logic fault_force,
    output logic gate_h,
    output logic gate_l
);

    localparam int CNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    leg_state_t       state;
    logic [CNT_W-1:0] dead_cnt;

    // Gates only turn on out of DEAD, so both sides can never be high together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= LEG_DEAD;
            dead_cnt <= CNT_RELOAD;
            gate_h   <= 1'b0;
            gate_l   <= 1'b0;
        end else if (fault_force) begin
            state    <= LEG_DEAD;
            dead_cnt <= CNT_RELOAD;
            gate_h   <= 1'b0;
            gate_l   <= 1'b0;
        end else if (enable) begin
            case (state)
                LEG_HIGH_ON: begin
                    if (!cmd) begin
                        state    <= LEG_DEAD;
                        dead_cnt <= CNT_RELOAD;
                        gate_h   <= 1'b0;
                    end
                end
                LEG_LOW_ON: begin
                    if (cmd) begin
                        state    <= LEG_DEAD;
                        dead_cnt <= CNT_RELOAD;
                        gate_l   <= 1'b0;
                    end
                end
                LEG_DEAD: begin
                    if (dead_cnt != '0) begin
                        dead_cnt <= dead_cnt - CNT_ONE;
                    end else if (cmd) begin
                        state  <= LEG_HIGH_ON;
                        gate_h <= 1'b1;
                    end else begin
                        state  <= LEG_LOW_ON;
                        gate_l <= 1'b1;
                    end
                end
                default: begin
                    state    <= LEG_DEAD;
                    dead_cnt <= CNT_RELOAD;
                    gate_h   <= 1'b0;
                    gate_l   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/svpwm_gate_driver.sv
// rtl/svpwm_gate_driver.sv - triangular-carrier SVPWM comparator and gate driver (optional SVPWM_FAULT_EN)
module svpwm_gate_driver
    import svpwm_pkg::*;
#(
    parameter int CARRIER_PEAK = 3125,
    parameter int DEAD_CYCLES  = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic signed [MOD_W-1:0] mod_a,
    input  logic signed [MOD_W-1:0] mod_b,
    input  logic signed [MOD_W-1:0] mod_c,
`ifdef SVPWM_FAULT_EN
    input  logic                    fault,
    output logic                    fault_latched,
`endif
    output logic                    gate_ah,
    output logic                    gate_al,
    output logic                    gate_bh,
    output logic                    gate_bl,
    output logic                    gate_ch,
    output logic                    gate_cl,
    output logic signed [MOD_W-1:0] carrier,
    output logic                    valley_sync,
    output logic                    ce_out
);

    localparam logic signed [MOD_W-1:0] PEAK  = MOD_W'(CARRIER_PEAK);
    localparam logic signed [MOD_W-1:0] NPEAK = -PEAK;
    localparam logic signed [MOD_W-1:0] ONE   = MOD_W'(1);

    logic                    dir;
    logic                    dir_nxt;
    logic signed [MOD_W-1:0] carrier_nxt;
    logic signed [MOD_W-1:0] act_a;
    logic signed [MOD_W-1:0] act_b;
    logic signed [MOD_W-1:0] act_c;
    logic [2:0]              cmd_r;
    logic                    fault_force;

    assign ce_out = clk_enable;

    // Each extreme is visited for exactly one clock before turning around.
    always_comb begin
        carrier_nxt = carrier;
        dir_nxt     = dir;
        if (carrier == PEAK) begin
            carrier_nxt = PEAK - ONE;
            dir_nxt     = DIR_DOWN;
        end else if (carrier == NPEAK) begin
            carrier_nxt = NPEAK + ONE;
            dir_nxt     = DIR_UP;
        end else if (dir == DIR_UP) begin
            carrier_nxt = carrier + ONE;
        end else begin
            carrier_nxt = carrier - ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carrier     <= NPEAK;
            dir         <= DIR_UP;
            valley_sync <= 1'b0;
            act_a       <= '0;
            act_b       <= '0;
            act_c       <= '0;
            cmd_r       <= '0;
        end else if (clk_enable) begin
            carrier     <= carrier_nxt;
            dir         <= dir_nxt;
            valley_sync <= (carrier_nxt == NPEAK);
            cmd_r[0]    <= (act_a > carrier);
            cmd_r[1]    <= (act_b > carrier);
            cmd_r[2]    <= (act_c > carrier);
            // Compare values only change at the valley so each carrier period sees one duty.
            if (carrier == NPEAK) begin
                act_a <= clamp_mod(mod_a, PEAK);
                act_b <= clamp_mod(mod_b, PEAK);
                act_c <= clamp_mod(mod_c, PEAK);
            end
        end
    end

`ifdef SVPWM_FAULT_EN
    logic fault_s1;
    logic fault_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_s1      <= 1'b0;
            fault_s2      <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            fault_s1 <= fault;
            fault_s2 <= fault_s1;
            if (fault_s2) begin
                fault_latched <= 1'b1;
            end
        end
    end

    assign fault_force = fault_s2 | fault_latched;
`else
    assign fault_force = 1'b0;
`endif

    svpwm_deadtime_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_a (
        .clk         (clk),
        .reset       (reset),
        .enable      (clk_enable),
        .cmd         (cmd_r[0]),
        .fault_force (fault_force),
        .gate_h      (gate_ah),
        .gate_l      (gate_al)
    );

    svpwm_deadtime_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_b (
        .clk         (clk),
        .reset       (reset),
        .enable      (clk_enable),
        .cmd         (cmd_r[1]),
        .fault_force (fault_force),
        .gate_h      (gate_bh),
        .gate_l      (gate_bl)
    );

    svpwm_deadtime_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_c (
        .clk         (clk),
        .reset       (reset),
        .enable      (clk_enable),
        .cmd         (cmd_r[2]),
        .fault_force (fault_force),
        .gate_h      (gate_ch),
        .gate_l      (gate_cl)
    );

endmodule

// File: tb/tb_svpwm_gate_driver.sv
// tb/tb_svpwm_gate_driver.sv - self-checking bench for svpwm_gate_driver (two dead-time settings)
module tb_svpwm_gate_driver;

    localparam int P = 8;

    logic               clk;
    logic               reset;
    logic               clk_enable;
    logic signed [15:0] mod_a;
    logic signed [15:0] mod_b;
    logic signed [15:0] mod_c;
    logic [2:0]         gh0, gl0, gh1, gl1;
    logic signed [15:0] carrier0, carrier1;
    logic               valley0, valley1;
    logic               ce0, ce1;
`ifdef SVPWM_FAULT_EN
    logic               fault;
    logic               fl0, fl1;
`endif

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    svpwm_gate_driver #(.CARRIER_PEAK(P), .DEAD_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .mod_a(mod_a), .mod_b(mod_b), .mod_c(mod_c),
`ifdef SVPWM_FAULT_EN
        .fault(fault), .fault_latched(fl0),
`endif
        .gate_ah(gh0[0]), .gate_al(gl0[0]), .gate_bh(gh0[1]), .gate_bl(gl0[1]),
        .gate_ch(gh0[2]), .gate_cl(gl0[2]),
        .carrier(carrier0), .valley_sync(valley0), .ce_out(ce0)
    );

    svpwm_gate_driver #(.CARRIER_PEAK(P), .DEAD_CYCLES(5)) dut1 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .mod_a(mod_a), .mod_b(mod_b), .mod_c(mod_c),
`ifdef SVPWM_FAULT_EN
        .fault(fault), .fault_latched(fl1),
`endif
        .gate_ah(gh1[0]), .gate_al(gl1[0]), .gate_bh(gh1[1]), .gate_bl(gl1[1]),
        .gate_ch(gh1[2]), .gate_cl(gl1[2]),
        .carrier(carrier1), .valley_sync(valley1), .ce_out(ce1)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: carrier as a closed-form function of enabled clocks since reset;
    // each leg tracked as "which side is on" plus elapsed off-clocks.
    int  t_m;
    int  act_m[3];
    bit  cmd_m[3];
    bit  cold_m[3];
    int  side_m[2][3];
    int  el_m[2][3];
    bit  valley_m;
    int  mv[3];
    int  c_m;
    int  dead_m[2] = '{2, 5};

    function automatic int car_at(input int tt);
        int ph;
        ph = tt % (4 * P);
        return (ph <= 2 * P) ? ph - P : 3 * P - ph;
    endfunction

    function automatic int clampi(input int v);
        return (v > P) ? P : ((v < -P) ? -P : v);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t_m = 0;
            valley_m = 0;
            for (int k = 0; k < 3; k++) begin
                act_m[k] = 0;
                cmd_m[k] = 0;
                for (int i = 0; i < 2; i++) begin
                    side_m[i][k] = 0;
                    el_m[i][k] = 1;
                end
            end
        end else if (clk_enable) begin
            mv[0] = int'(mod_a);
            mv[1] = int'(mod_b);
            mv[2] = int'(mod_c);
            c_m = car_at(t_m);
            for (int k = 0; k < 3; k++) begin
                cold_m[k] = cmd_m[k];
                cmd_m[k] = (act_m[k] > c_m);
            end
            if (c_m == -P)
                for (int k = 0; k < 3; k++) act_m[k] = clampi(mv[k]);
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 3; k++) begin
                    if (side_m[i][k] == 0) begin
                        if (el_m[i][k] >= dead_m[i]) side_m[i][k] = cold_m[k] ? 1 : 2;
                        else el_m[i][k]++;
                    end else if ((side_m[i][k] == 1) != cold_m[k]) begin
                        side_m[i][k] = 0;
                        el_m[i][k] = 1;
                    end
                end
            end
            t_m++;
            valley_m = (car_at(t_m) == -P);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("carrier0", int'(carrier0), car_at(t_m));
            check("carrier1", int'(carrier1), car_at(t_m));
            check("valley0", int'(valley0), int'(valley_m));
            check("valley1", int'(valley1), int'(valley_m));
            for (int k = 0; k < 3; k++) begin
                check("gate_h_d2", int'(gh0[k]), int'(side_m[0][k] == 1));
                check("gate_l_d2", int'(gl0[k]), int'(side_m[0][k] == 2));
                check("gate_h_d5", int'(gh1[k]), int'(side_m[1][k] == 1));
                check("gate_l_d5", int'(gl1[k]), int'(side_m[1][k] == 2));
            end
            check("overlap", int'((gh0 & gl0) | (gh1 & gl1)), 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // High-side and low-side on-counts over one carrier period.
    task automatic measure(input int k, output int h0, output int l0, output int h1, output int l1);
        h0 = 0; l0 = 0; h1 = 0; l1 = 0;
        repeat (4 * P) begin
            @(negedge clk);
            h0 += int'(gh0[k]);
            l0 += int'(gl0[k]);
            h1 += int'(gh1[k]);
            l1 += int'(gl1[k]);
        end
    endtask

    int h0, l0, h1, l1;

    initial begin
        reset = 1;
        clk_enable = 1;
        mod_a = 0;
        mod_b = 0;
        mod_c = 0;
`ifdef SVPWM_FAULT_EN
        fault = 0;
`endif
        @(posedge clk);
        #1 cmp_en = 1;
        @(negedge clk);
        check("rst_carrier", int'(carrier0), -8);
        check("rst_gates", int'({gh0, gl0, gh1, gl1}), 0);
        check("rst_valley", int'(valley0), 0);
        reset = 0;
        @(posedge clk);
        #1 check("edge1_high", int'(gh0), 0);
        @(posedge clk);
        #1 check("edge2_high", int'(gh0), 7);
        check("edge2_low", int'(gl0), 0);

        cyc(64);
        measure(0, h0, l0, h1, l1);
        check("mod0_h_d2", h0, 13);
        check("mod0_l_d2", l0, 15);
        check("mod0_h_d5", h1, 10);
        check("mod0_l_d5", l1, 12);

        mod_a = 100;
        cyc(96);
        measure(0, h0, l0, h1, l1);
        check("pos_clamp_h_d2", h0, 30);
        check("pos_clamp_l_d2", l0, 0);
        check("pos_clamp_h_d5", h1, 27);
        check("pos_clamp_l_d5", l1, 0);

        mod_a = -100;
        cyc(96);
        measure(0, h0, l0, h1, l1);
        check("neg_clamp_h_d2", h0, 0);
        check("neg_clamp_l_d2", l0, 32);
        check("neg_clamp_l_d5", l1, 32);

        cyc(10);
        mod_b = 4;
        cyc(96);
        measure(1, h0, l0, h1, l1);
        check("modb4_h_d2", h0, 21);
        check("modb4_l_d2", l0, 7);
        check("modb4_h_d5", h1, 18);
        check("modb4_l_d5", l1, 4);

        cyc(5);
        clk_enable = 0;
        #1 check("ce_out_low", int'(ce0), 0);
        cyc(20);
        clk_enable = 1;
        #1 check("ce_out_high", int'(ce1), 1);
        cyc(40);

        @(posedge clk);
        #2 reset = 1;
        #1 check("async_rst_gates", int'({gh0, gl0, gh1, gl1}), 0);
        cyc(2);
        reset = 0;
        @(posedge clk);
        @(posedge clk);
        #1 check("rerst_edge2_high", int'(gh0), 7);
        cyc(100);

`ifdef SVPWM_FAULT_EN
        cmp_en = 0;
        @(negedge clk);
        fault = 1;
        @(negedge clk);
        fault = 0;
        @(posedge clk);
        @(posedge clk);
        #1 check("fault_gates", int'({gh0, gl0, gh1, gl1}), 0);
        check("fault_latched", int'(fl0), 1);
        cyc(40);
        check("fault_hold_gates", int'({gh0, gl0, gh1, gl1}), 0);
        check("fault_hold_latch", int'(fl1), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
